ar_id_allocator: RTL and testbench
==================================

Name: ar_id_allocator

Overview:
- Issue-side counterpart of the R-path ordering unit.
- Accepts read requests carrying an original ID and binds each original ID to a row.
- Hands out per-row column indices in strict wrap-around order and forwards each request downstream tagged with unique ID uid = {row,col}.
- Reclaims uids on free requests from the ordering unit, and translates uid back to the original ID (restored_id) for the R path.

Parameters:
ID_WIDTH, 4, original ID width
MAX_OUTSTANDING, 16, sizing base for the row/column table
NUM_ROWS, MAX_OUTSTANDING, number of distinct original IDs tracked at once
NUM_COLS, MAX_OUTSTANDING, outstanding requests per row
ROW_W, $clog2(NUM_ROWS), row index width (localparam)
COL_W, $clog2(NUM_COLS), column index width (localparam)
UID_W, ROW_W+COL_W, unique ID width; uid = {row,col}

Ports:
clk  input  1  clock; one clock domain
rst  input  1  asynchronous, active-low reset (asserted when 0)
ar_in_valid  input  1  upstream request valid
ar_in_ready  output  1  upstream request accepted when valid&ready
ar_in_id  input  ID_WIDTH  original ID of the request
ar_out_valid  output  1  tagged request valid downstream
ar_out_ready  input  1  downstream accepts when valid&ready
ar_out_uid  output  UID_W  allocated {row,col}
free_req  input  1  ordering unit released the response with uid free_uid
free_uid  input  UID_W  uid being retired
lookup_uid  input  UID_W  uid to translate
restored_id  output  ID_WIDTH  original ID bound to lookup_uid's row (combinational)
free_err  output  1  sticky error: free received for a row with zero outstanding
full  output  1  no free row and every valid row at NUM_COLS outstanding

Behaviour:
- Per-row state: row_valid, row_id[ID_WIDTH], alloc_idx[COL_W], out_cnt (0..NUM_COLS, width $clog2(NUM_COLS+1)).
- Reset (rst=0, asynchronous): all state 0. Outputs ar_out_valid=0, ar_out_uid=0, ar_in_ready=0, free_err=0, full=0, restored_id=0 (row_id cleared).
- Row select, combinational on ar_in_id:
  - Hit = some row with row_valid && row_id==ar_in_id; at most one such row exists.
  - Otherwise use the lowest-index row with row_valid==0.
- Allocatable when:
  - hit row has out_cnt<NUM_COLS, or
  - there is no hit and a free row exists.
- ar_in_ready = allocatable && (!ar_out_valid || ar_out_ready). ar_in_ready does not depend on ar_in_valid.
- Acceptance (ar_in_valid && ar_in_ready):
  - Next cycle: ar_out_valid=1 and ar_out_uid={row, alloc_idx[row]}.
  - alloc_idx[row] increments, wrapping from NUM_COLS-1 to 0.
  - out_cnt[row] increments.
  - On a new row: row_valid=1 and row_id=ar_in_id.
  - Latency is 1 cycle. Full throughput of one request per cycle while ar_out_ready=1.
- Output stage: ar_out_valid/ar_out_uid hold stable until ar_out_ready. It clears after a handshake with no new acceptance.
- Column order must match the ordering unit's release_idx: both start at 0 after reset and wrap identically.
- Free (free_req=1), row = free_uid[UID_W-1:COL_W]; the column bits are not checked:
  - out_cnt[row] decrements.
  - If out_cnt reaches 0 with no same-cycle acceptance to that row, row_valid clears.
  - alloc_idx[row] is not reset, so columns keep cycling across re-binding.
- Free when out_cnt[row]==0: free is ignored and free_err sets, held until reset.
- Simultaneous accept and free on the same row: out_cnt unchanged, row stays valid.
- Simultaneous free to zero on row X and a new-ID accept: row-select uses pre-update state, so X is not reused that cycle.
- full reflects registered state; it is updated the cycle after the change.
- restored_id = row_id[lookup_uid[UID_W-1:COL_W]]. The value is undefined-but-stable (the stored row_id) when that row is invalid.
- Reset asserted mid-operation: any pending ar_out_valid is dropped immediately, all bindings are lost, and allocation restarts at uid 0.

Test Plan:
- Single ID: after reset, 3 requests with ar_in_id=4'h5 and ar_out_ready=1 -> uids {0,0},{0,1},{0,2} on consecutive cycles; restored_id for lookup {0,1} = 5.
- Two IDs interleaved: ids A,B,A -> uids {0,0},{1,0},{0,1}. Then free {0,0},{0,1} -> row 0 invalid; next new ID C -> row 0, col 2.
- Column wrap/stall: NUM_COLS=4, 4 requests id 3 with no frees -> 5th held, ar_in_ready=0. Free {0,0} -> 5th accepted next cycle with uid {0,0}.
- Backpressure: ar_out_ready=0 with ar_out_valid=1 -> ar_out_uid stable and ar_in_ready=0. Release -> queued request issues next cycle with no uid skipped.
- Simultaneous accept+free, same row holding 1 outstanding -> out_cnt stays 1 and row stays valid. Spurious free to an empty row -> free_err=1 and sticky.
- Async reset asserted while ar_out_valid=1 -> ar_out_valid=0 immediately. After release, first uid = {0,0}.

Source files
------------

// File: rtl/ar_id_allocator.sv
// Read-request ID allocator: binds original IDs to table rows, issues {row,col} uids
// in per-row wrap-around order, reclaims them on free, and maps uids back to IDs.
module ar_id_allocator #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned NUM_ROWS        = MAX_OUTSTANDING,
  parameter int unsigned NUM_COLS        = MAX_OUTSTANDING,
  localparam int unsigned ROW_W          = $clog2(NUM_ROWS),
  localparam int unsigned COL_W          = $clog2(NUM_COLS),
  localparam int unsigned UID_W          = ROW_W + COL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ar_in_valid,
  output logic                ar_in_ready,
  input  logic [ID_WIDTH-1:0] ar_in_id,
  output logic                ar_out_valid,
  input  logic                ar_out_ready,
  output logic [UID_W-1:0]    ar_out_uid,
  input  logic                free_req,
  input  logic [UID_W-1:0]    free_uid,
  input  logic [UID_W-1:0]    lookup_uid,
  output logic [ID_WIDTH-1:0] restored_id,
  output logic                free_err,
  output logic                full
);

  localparam int unsigned CNT_W = $clog2(NUM_COLS + 1);

  logic [NUM_ROWS-1:0] r_row_valid;
  logic [ID_WIDTH-1:0] r_row_id    [NUM_ROWS];
  logic [COL_W-1:0]    r_alloc_idx [NUM_ROWS];
  logic [CNT_W-1:0]    r_out_cnt   [NUM_ROWS];
  logic                r_out_valid;
  logic [UID_W-1:0]    r_out_uid;
  logic                r_free_err;
  logic                r_full;
  logic                r_live;

  logic                w_hit;
  logic [ROW_W-1:0]    w_hit_row;
  logic                w_free_avail;
  logic [ROW_W-1:0]    w_free_row;
  logic [ROW_W-1:0]    w_sel_row;
  logic                w_alloc_ok;
  logic                w_accept;
  logic [ROW_W-1:0]    w_rel_row;
  logic                w_rel_ok;
  logic                w_rel_bad;
  logic [NUM_ROWS-1:0] w_acc_vec;
  logic [NUM_ROWS-1:0] w_rel_vec;
  logic                w_full_c;
  logic                w_unused_cols;

  // Row select: ID hit first, else lowest unbound row.
  always_comb begin
    w_hit        = 1'b0;
    w_hit_row    = '0;
    w_free_avail = 1'b0;
    w_free_row   = '0;
    for (int i = 0; i < int'(NUM_ROWS); i++) begin
      if (r_row_valid[i] && (r_row_id[i] == ar_in_id)) begin
        w_hit     = 1'b1;
        w_hit_row = ROW_W'(i);
      end
    end
    for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
      if (!r_row_valid[i]) begin
        w_free_avail = 1'b1;
        w_free_row   = ROW_W'(i);
      end
    end
  end

  assign w_sel_row   = w_hit ? w_hit_row : w_free_row;
  assign w_alloc_ok  = w_hit ? (r_out_cnt[w_hit_row] < CNT_W'(NUM_COLS)) : w_free_avail;
  assign ar_in_ready = r_live && w_alloc_ok && (!r_out_valid || ar_out_ready);
  assign w_accept    = ar_in_valid && ar_in_ready;

  // Column bits of free/lookup uids are intentionally ignored.
  assign w_rel_row     = free_uid[UID_W-1:COL_W];
  assign w_rel_ok      = free_req && (r_out_cnt[w_rel_row] != '0);
  assign w_rel_bad     = free_req && (r_out_cnt[w_rel_row] == '0);
  assign w_unused_cols = ^{free_uid[COL_W-1:0], lookup_uid[COL_W-1:0]};

  always_comb begin
    w_acc_vec = '0;
    w_rel_vec = '0;
    w_full_c  = &r_row_valid;
    for (int i = 0; i < int'(NUM_ROWS); i++) begin
      w_acc_vec[i] = w_accept && (w_sel_row == ROW_W'(i));
      w_rel_vec[i] = w_rel_ok && (w_rel_row == ROW_W'(i));
      if (r_out_cnt[i] != CNT_W'(NUM_COLS)) begin
        w_full_c = 1'b0;
      end
    end
  end

  // Per-row binding, column pointer and outstanding count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_valid <= '0;
      for (int i = 0; i < int'(NUM_ROWS); i++) begin
        r_row_id[i]    <= '0;
        r_alloc_idx[i] <= '0;
        r_out_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_ROWS); i++) begin
        if (w_acc_vec[i] && !w_rel_vec[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] + CNT_W'(1);
        end else if (w_rel_vec[i] && !w_acc_vec[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] - CNT_W'(1);
        end
        if (w_acc_vec[i]) begin
          r_alloc_idx[i] <= (r_alloc_idx[i] == COL_W'(NUM_COLS - 1)) ? '0
                                                                     : r_alloc_idx[i] + COL_W'(1);
          r_row_valid[i] <= 1'b1;
          if (!r_row_valid[i]) begin
            r_row_id[i] <= ar_in_id;
          end
        end else if (w_rel_vec[i] && (r_out_cnt[i] == CNT_W'(1))) begin
          r_row_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output register stage, status flags and post-reset enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_uid   <= '0;
      r_free_err  <= 1'b0;
      r_full      <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_full <= w_full_c;
      if (w_rel_bad) begin
        r_free_err <= 1'b1;
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_uid   <= {w_sel_row, r_alloc_idx[w_sel_row]};
      end else if (ar_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign ar_out_valid = r_out_valid;
  assign ar_out_uid   = r_out_uid;
  assign free_err     = r_free_err;
  assign full         = r_full;
  assign restored_id  = r_row_id[lookup_uid[UID_W-1:COL_W]];

endmodule

// File: tb/tb_ar_id_allocator.sv
// Directed bench for ar_id_allocator with a 4x4 row/column table.
module tb_ar_id_allocator;

  localparam int unsigned IDW   = 4;
  localparam int unsigned UIDW  = 4;

  logic            clk;
  logic            rst;
  logic            ar_in_valid;
  logic            ar_in_ready;
  logic [IDW-1:0]  ar_in_id;
  logic            ar_out_valid;
  logic            ar_out_ready;
  logic [UIDW-1:0] ar_out_uid;
  logic            free_req;
  logic [UIDW-1:0] free_uid;
  logic [UIDW-1:0] lookup_uid;
  logic [IDW-1:0]  restored_id;
  logic            free_err;
  logic            full;

  int n_total;
  int n_bad;

  ar_id_allocator #(
    .ID_WIDTH(4), .MAX_OUTSTANDING(4), .NUM_ROWS(4), .NUM_COLS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ar_in_valid(ar_in_valid), .ar_in_ready(ar_in_ready), .ar_in_id(ar_in_id),
    .ar_out_valid(ar_out_valid), .ar_out_ready(ar_out_ready), .ar_out_uid(ar_out_uid),
    .free_req(free_req), .free_uid(free_uid),
    .lookup_uid(lookup_uid), .restored_id(restored_id),
    .free_err(free_err), .full(full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ar_in_valid = 1'b0;
    free_req    = 1'b0;
    rst         = 1'b0;
    #2;
    rst         = 1'b1;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    ar_in_valid = 1'b0; ar_in_id = '0; ar_out_ready = 1'b0;
    free_req = 1'b0; free_uid = '0; lookup_uid = '0;
    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(ar_out_valid), 0);
    chk("rst_out_uid", 32'(ar_out_uid), 0);
    chk("rst_in_ready", 32'(ar_in_ready), 0);
    chk("rst_free_err", 32'(free_err), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_restored", 32'(restored_id), 0);
    rst = 1'b1;
    tick();
    chk("live_in_ready", 32'(ar_in_ready), 1);

    // single ID, three back-to-back requests
    ar_out_ready = 1'b1; ar_in_valid = 1'b1; ar_in_id = 4'h5;
    tick(); chk("t1_valid0", 32'(ar_out_valid), 1); chk("t1_uid0", 32'(ar_out_uid), 32'h0);
    tick(); chk("t1_uid1", 32'(ar_out_uid), 32'h1);
    tick(); chk("t1_uid2", 32'(ar_out_uid), 32'h2);
    ar_in_valid = 1'b0; lookup_uid = 4'h1; #1;
    chk("t1_restored", 32'(restored_id), 32'h5);
    tick(); chk("t1_drain", 32'(ar_out_valid), 0);

    // two IDs interleaved, free row 0, rebind with column continuing
    do_reset();
    ar_in_valid = 1'b1; ar_in_id = 4'h1;
    tick(); chk("t2_a0", 32'(ar_out_uid), 32'h0);
    ar_in_id = 4'h2;
    tick(); chk("t2_b0", 32'(ar_out_uid), 32'h4);
    ar_in_id = 4'h1;
    tick(); chk("t2_a1", 32'(ar_out_uid), 32'h1);
    ar_in_valid = 1'b0; free_req = 1'b1; free_uid = 4'h0;
    tick();
    free_uid = 4'h1;
    tick();
    free_req = 1'b0; ar_in_valid = 1'b1; ar_in_id = 4'h7;
    tick(); chk("t2_c_valid", 32'(ar_out_valid), 1); chk("t2_c_uid", 32'(ar_out_uid), 32'h2);
    ar_in_valid = 1'b0; lookup_uid = 4'h2; #1;
    chk("t2_restored", 32'(restored_id), 32'h7);
    chk("t2_no_err", 32'(free_err), 0);

    // column exhaustion stalls until a free
    do_reset();
    ar_in_valid = 1'b1; ar_in_id = 4'h3;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("t3_uid", 32'(ar_out_uid), 32'(k));
    end
    chk("t3_stall_ready", 32'(ar_in_ready), 0);
    tick();
    chk("t3_stall_valid", 32'(ar_out_valid), 0);
    chk("t3_stall_ready2", 32'(ar_in_ready), 0);
    free_req = 1'b1; free_uid = 4'h0;
    tick();
    free_req = 1'b0;
    chk("t3_ready_after_free", 32'(ar_in_ready), 1);
    tick(); chk("t3_fifth_valid", 32'(ar_out_valid), 1); chk("t3_fifth_uid", 32'(ar_out_uid), 32'h0);
    ar_in_valid = 1'b0;

    // fill all rows and columns; full lags state by one cycle
    do_reset();
    ar_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ar_in_id = 4'(i / 4);
      tick(); chk("t_fill_uid", 32'(ar_out_uid), 32'(i));
    end
    ar_in_valid = 1'b0;
    chk("t_full_lag", 32'(full), 0);
    tick(); chk("t_full_set", 32'(full), 1);
    ar_in_id = 4'h9; #1;
    chk("t_full_ready", 32'(ar_in_ready), 0);

    // backpressure holds output, no uid skipped on release
    do_reset();
    ar_out_ready = 1'b0; ar_in_valid = 1'b1; ar_in_id = 4'h6;
    tick(); chk("t4_v", 32'(ar_out_valid), 1); chk("t4_uid0", 32'(ar_out_uid), 0);
    chk("t4_ready0", 32'(ar_in_ready), 0);
    tick(); chk("t4_hold_v", 32'(ar_out_valid), 1); chk("t4_hold_uid", 32'(ar_out_uid), 0);
    ar_out_ready = 1'b1; #1;
    chk("t4_ready_rel", 32'(ar_in_ready), 1);
    tick(); chk("t4_uid1", 32'(ar_out_uid), 32'h1); chk("t4_v1", 32'(ar_out_valid), 1);
    ar_in_valid = 1'b0;
    tick(); chk("t4_drain", 32'(ar_out_valid), 0);

    // simultaneous accept+free keeps row bound; spurious free is sticky
    do_reset();
    ar_in_valid = 1'b1; ar_in_id = 4'h8;
    tick(); chk("t5_uid0", 32'(ar_out_uid), 0);
    free_req = 1'b1; free_uid = 4'h0;
    tick(); chk("t5_uid1", 32'(ar_out_uid), 32'h1);
    free_req = 1'b0; ar_in_id = 4'h9;
    tick(); chk("t5_row_kept", 32'(ar_out_uid), 32'h4);
    ar_in_valid = 1'b0; free_req = 1'b1; free_uid = 4'h0;
    tick();
    free_req = 1'b0; ar_in_valid = 1'b1; ar_in_id = 4'hA;
    tick(); chk("t5_rebind", 32'(ar_out_uid), 32'h2);
    ar_in_valid = 1'b0;
    chk("t5_err_clear", 32'(free_err), 0);
    free_req = 1'b1; free_uid = 4'hC;
    tick(); chk("t5_err_set", 32'(free_err), 1);
    free_req = 1'b0;
    tick(); chk("t5_err_sticky", 32'(free_err), 1);

    // async reset mid-operation
    do_reset();
    ar_out_ready = 1'b1; ar_in_valid = 1'b1; ar_in_id = 4'h1;
    tick(); tick();
    ar_in_valid = 1'b0; ar_out_ready = 1'b0;
    chk("t6_pre_valid", 32'(ar_out_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(ar_out_valid), 0);
    chk("t6_async_uid", 32'(ar_out_uid), 0);
    rst = 1'b1;
    tick();
    ar_out_ready = 1'b1; ar_in_valid = 1'b1; ar_in_id = 4'h2;
    tick(); chk("t6_restart_v", 32'(ar_out_valid), 1); chk("t6_restart_uid", 32'(ar_out_uid), 0);
    ar_in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
